// File: rtl/param_bus_datapath_pkg.sv
// param_bus_datapath_pkg: bus-source indices, memory FSM states and sizing helper for the datapath
package param_bus_datapath_pkg;
  localparam int SRC_REG0 = 0;
  localparam int SRC_HI = 0;
  localparam int SRC_LO = 1;
  localparam int SRC_ZHI = 2;
  localparam int SRC_ZLO = 3;
  localparam int SRC_PC = 4;
  localparam int SRC_MDR = 5;
  localparam int SRC_C = 6;
  localparam int NUM_SPECIAL = 7;
  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_e;
  function automatic int src_cnt_w(input int num_regs);
    return $clog2(num_regs + NUM_SPECIAL + 1);
  endfunction
endpackage

// File: rtl/param_bus_datapath_if.sv
// param_bus_datapath_if: memory handshake between the datapath (master) and memory (slave)
interface param_bus_datapath_if #(parameter int DATA_W = 32);
  logic req, we, ack;
  logic [DATA_W-1:0] addr, wdata, rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/param_bus_datapath_mem_handshake_fsm.sv
// param_bus_datapath_mem_handshake_fsm: memory request FSM with timeout, and MAR/MDR load gating while busy
module param_bus_datapath_mem_handshake_fsm
  import param_bus_datapath_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic mem_ack,
  input  logic mar_in,
  input  logic mdr_in,
  input  logic err_clr,
  output logic mem_req,
  output logic mem_we,
  output logic busy,
  output logic mem_done,
  output logic mem_err,
  output logic mar_ld,
  output logic mdr_bus_ld,
  output logic mdr_mem_ld
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  mem_state_e state;
  logic [CNT_W-1:0] cnt;
  logic timeout;
  assign timeout = cnt == CNT_W'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      busy <= 1'b0;
      mem_done <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      if (err_clr) mem_err <= 1'b0;
      case (state)
        IDLE: if (mem_rd || mem_wr) begin
          state <= REQ;
          cnt <= '0;
          mem_req <= 1'b1;
          busy <= 1'b1;
          mem_we <= !mem_rd;
        end
        REQ: if (mem_ack) begin
          state <= DONE;
          mem_req <= 1'b0;
          mem_done <= 1'b1;
        end else if (timeout) begin
          state <= IDLE;
          mem_req <= 1'b0;
          busy <= 1'b0;
          mem_we <= 1'b0;
          mem_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  assign mar_ld = mar_in && !busy;
  assign mdr_bus_ld = mdr_in && !busy;
  assign mdr_mem_ld = mem_req && mem_ack && !mem_we;
endmodule

// File: rtl/param_bus_datapath.sv
// param_bus_datapath: single-bus CPU datapath with register file, priority bus mux, contention flag and memory handshake
module param_bus_datapath
  import param_bus_datapath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int R0_ZERO = 0,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] PC_STEP = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_REGS-1:0] reg_out,
  input  logic [NUM_REGS-1:0] reg_in,
  input  logic pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, c_out,
  input  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
  input  logic inc_pc,
  input  logic [DATA_W-1:0] c_value,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic err_clr,
  param_bus_datapath_if.master mem,
  output logic busy,
  output logic mem_done,
  output logic mem_err,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] pc_val,
  output logic [DATA_W-1:0] ir_val,
  output logic bus_err
);
  localparam int NUM_SRC = NUM_REGS + NUM_SPECIAL;
  localparam int CW = src_cnt_w(NUM_REGS);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] src [NUM_SRC];
  logic [NUM_SRC-1:0] en;
  logic [CW-1:0] n_drv;
  logic [DATA_W-1:0] pc, ir, mar, mdr, y, hi, lo;
  logic [2*DATA_W-1:0] z;
  logic mar_ld, mdr_bus_ld, mdr_mem_ld;
  assign en = {c_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out, reg_out};
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) src[SRC_REG0 + i] = (R0_ZERO != 0 && i == 0) ? '0 : regs[i];
    src[NUM_REGS + SRC_HI] = hi;
    src[NUM_REGS + SRC_LO] = lo;
    src[NUM_REGS + SRC_ZHI] = z[2*DATA_W-1:DATA_W];
    src[NUM_REGS + SRC_ZLO] = z[DATA_W-1:0];
    src[NUM_REGS + SRC_PC] = pc;
    src[NUM_REGS + SRC_MDR] = mdr;
    src[NUM_REGS + SRC_C] = c_value;
  end
  // walk from the weakest source down so the lowest enabled index ends up on the bus
  always_comb begin
    bus = '0;
    n_drv = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      bus = en[i] ? src[i] : bus;
      n_drv = n_drv + CW'(en[i]);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pc <= RESET_PC;
      ir <= '0;
      mar <= '0;
      mdr <= '0;
      y <= '0;
      hi <= '0;
      lo <= '0;
      z <= '0;
      bus_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_in[i] && !(R0_ZERO != 0 && i == 0)) regs[i] <= bus;
      pc <= pc_in ? bus : inc_pc ? pc + PC_STEP : pc;
      ir <= ir_in ? bus : ir;
      y <= y_in ? bus : y;
      hi <= hi_in ? bus : hi;
      lo <= lo_in ? bus : lo;
      z <= z_in ? alu_result : z;
      mar <= mar_ld ? bus : mar;
      mdr <= mdr_mem_ld ? mem.rdata : mdr_bus_ld ? bus : mdr;
      bus_err <= (n_drv > CW'(1)) ? 1'b1 : err_clr ? 1'b0 : bus_err;
    end
  param_bus_datapath_mem_handshake_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_fsm (
    .clk(clk),
    .reset(reset),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_ack(mem.ack),
    .mar_in(mar_in),
    .mdr_in(mdr_in),
    .err_clr(err_clr),
    .mem_req(mem.req),
    .mem_we(mem.we),
    .busy(busy),
    .mem_done(mem_done),
    .mem_err(mem_err),
    .mar_ld(mar_ld),
    .mdr_bus_ld(mdr_bus_ld),
    .mdr_mem_ld(mdr_mem_ld)
  );
  assign mem.addr = mar;
  assign mem.wdata = mdr;
  assign alu_a = y;
  assign alu_b = bus;
  assign pc_val = pc;
  assign ir_val = ir;
endmodule

// File: tb/tb_param_bus_datapath.sv
// tb_param_bus_datapath: directed and random checks of the bus datapath against a queue-based reference model
module tb_param_bus_datapath;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] reg_out, reg_in;
  logic pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, c_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc;
  logic [31:0] c_value;
  logic [63:0] alu_result;
  logic [31:0] alu_a, alu_b, bus, pc_val, ir_val;
  logic mem_rd, mem_wr, err_clr, busy, mem_done, mem_err, bus_err;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_reg [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
  logic [63:0] m_z;
  logic m_berr, m_merr, m_busy, m_rd_req;

  param_bus_datapath_if #(.DATA_W(32)) mem_if ();

  param_bus_datapath #(
    .DATA_W(32), .NUM_REGS(16), .R0_ZERO(1), .RESET_PC(32'h100), .PC_STEP(32'd4), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .reg_out(reg_out), .reg_in(reg_in),
    .pc_out(pc_out), .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .mdr_out(mdr_out), .c_out(c_out), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .inc_pc(inc_pc),
    .c_value(c_value), .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .err_clr(err_clr), .mem(mem_if),
    .busy(busy), .mem_done(mem_done), .mem_err(mem_err), .bus(bus), .pc_val(pc_val),
    .ir_val(ir_val), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    reg_out = '0;
    reg_in = '0;
    {pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, c_out} = 7'b0;
    {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc} = 9'b0;
    c_value = '0;
    alu_result = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    err_clr = 1'b0;
    mem_if.ack = 1'b0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pc = 32'h100;
    {m_ir, m_mar, m_mdr, m_y, m_hi, m_lo} = '0;
    m_z = '0;
    {m_berr, m_merr, m_busy, m_rd_req} = 4'b0;
  endtask

  // all enabled sources in priority order; the first one owns the bus
  function automatic logic [31:0] exp_bus(output int n);
    logic [31:0] q[$];
    for (int i = 0; i < 16; i++) if (reg_out[i]) q.push_back(i == 0 ? 32'd0 : m_reg[i]);
    if (hi_out) q.push_back(m_hi);
    if (lo_out) q.push_back(m_lo);
    if (zhi_out) q.push_back(m_z[63:32]);
    if (zlo_out) q.push_back(m_z[31:0]);
    if (pc_out) q.push_back(m_pc);
    if (mdr_out) q.push_back(m_mdr);
    if (c_out) q.push_back(c_value);
    n = q.size();
    return n == 0 ? 32'd0 : q[0];
  endfunction

  task automatic cycle(input string tag);
    logic [31:0] eb;
    int n;
    eb = exp_bus(n);
    #1;
    chk({tag, ":bus"}, 64'(bus), 64'(eb));
    chk({tag, ":alu_b"}, 64'(alu_b), 64'(eb));
    @(posedge clk);
    if (n > 1) m_berr = 1'b1;
    else if (err_clr) m_berr = 1'b0;
    if (err_clr) m_merr = 1'b0;
    for (int i = 1; i < 16; i++) if (reg_in[i]) m_reg[i] = eb;
    m_pc = pc_in ? eb : inc_pc ? m_pc + 32'd4 : m_pc;
    if (ir_in) m_ir = eb;
    if (y_in) m_y = eb;
    if (hi_in) m_hi = eb;
    if (lo_in) m_lo = eb;
    if (z_in) m_z = alu_result;
    if (m_busy) begin
      if (m_rd_req && mem_if.ack) m_mdr = mem_if.rdata;
    end else begin
      if (mar_in) m_mar = eb;
      if (mdr_in) m_mdr = eb;
    end
    #1;
    chk({tag, ":pc"}, 64'(pc_val), 64'(m_pc));
    chk({tag, ":ir"}, 64'(ir_val), 64'(m_ir));
    chk({tag, ":alu_a"}, 64'(alu_a), 64'(m_y));
    chk({tag, ":mem_addr"}, 64'(mem_if.addr), 64'(m_mar));
    chk({tag, ":mem_wdata"}, 64'(mem_if.wdata), 64'(m_mdr));
    chk({tag, ":bus_err"}, 64'(bus_err), 64'(m_berr));
    chk({tag, ":mem_err"}, 64'(mem_err), 64'(m_merr));
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    mem_if.rdata = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 64'(pc_val), 64'h100);
    chk("rst_bus", 64'(bus), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req", 64'(mem_if.req), 64'd0);
    chk("rst_done", 64'(mem_done), 64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    chk("rst_ir", 64'(ir_val), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    reset = 1'b1;

    idle_in(); inc_pc = 1'b1;
    repeat (3) cycle("inc");
    chk("pc_inc3", 64'(pc_val), 64'h10C);
    idle_in(); c_value = 32'h20; c_out = 1'b1; pc_in = 1'b1; inc_pc = 1'b1;
    cycle("pc_load");
    chk("pc_load_wins", 64'(pc_val), 64'h20);

    idle_in(); c_value = 32'h5; c_out = 1'b1; reg_in[3] = 1'b1;
    cycle("r3_load");
    idle_in(); reg_out[3] = 1'b1; y_in = 1'b1;
    cycle("y_load");
    chk("r3_bus", 64'(bus), 64'h5);
    chk("y_val", 64'(alu_a), 64'h5);
    idle_in(); alu_result = 64'h0000000A_0000000F; z_in = 1'b1;
    cycle("z_load");
    idle_in(); zlo_out = 1'b1; reg_in[4] = 1'b1;
    cycle("zlo_r4");
    idle_in(); reg_out[4] = 1'b1;
    cycle("r4_read");
    chk("r4_val", 64'(bus), 64'hF);
    idle_in(); zhi_out = 1'b1; hi_in = 1'b1;
    cycle("zhi_hi");
    idle_in(); hi_out = 1'b1;
    cycle("hi_read");
    chk("hi_val", 64'(bus), 64'hA);

    idle_in(); c_value = 32'h77; c_out = 1'b1; reg_in[2] = 1'b1;
    cycle("r2_load");
    idle_in(); reg_out[2] = 1'b1; pc_out = 1'b1;
    cycle("contend");
    chk("contend_bus", 64'(bus), 64'h77);
    chk("contend_flag", 64'(bus_err), 64'd1);
    err_clr = 1'b1;
    cycle("clr_vs_set");
    chk("set_beats_clr", 64'(bus_err), 64'd1);
    idle_in(); err_clr = 1'b1;
    cycle("clr");
    chk("bus_err_clr", 64'(bus_err), 64'd0);

    idle_in(); c_value = 32'h40; c_out = 1'b1; mar_in = 1'b1;
    cycle("mar_load");
    idle_in(); mem_rd = 1'b1;
    cycle("rd_start");
    m_busy = 1'b1; m_rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle_in();
      mem_rd = 1'b1; c_value = 32'h1234; c_out = 1'b1; mdr_in = 1'b1; mar_in = 1'b1;
      mem_if.ack = (k == 2); mem_if.rdata = 32'hDEADBEEF;
      chk("rd_req", 64'(mem_if.req), 64'd1);
      chk("rd_busy", 64'(busy), 64'd1);
      chk("rd_we", 64'(mem_if.we), 64'd0);
      chk("rd_nodone", 64'(mem_done), 64'd0);
      cycle("rd_req");
    end
    m_rd_req = 1'b0;
    idle_in(); mem_if.ack = 1'b1; c_value = 32'h999; c_out = 1'b1; mdr_in = 1'b1; mem_rd = 1'b1;
    chk("rd_done", 64'(mem_done), 64'd1);
    chk("rd_done_req", 64'(mem_if.req), 64'd0);
    chk("rd_mdr", 64'(mem_if.wdata), 64'hDEADBEEF);
    cycle("rd_done");
    m_busy = 1'b0;
    idle_in(); mem_if.ack = 1'b1;
    chk("done_once", 64'(mem_done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    cycle("late_ack");
    chk("late_ack_ignored", 64'(busy), 64'd0);
    idle_in(); mdr_out = 1'b1;
    cycle("mdr_read");
    chk("mdr_bus", 64'(bus), 64'hDEADBEEF);

    idle_in(); c_value = 32'h55AA; c_out = 1'b1; mdr_in = 1'b1;
    cycle("mdr_load");
    idle_in(); mem_wr = 1'b1;
    cycle("wr_start");
    m_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle_in();
      chk("wr_req", 64'(mem_if.req), 64'd1);
      chk("wr_we", 64'(mem_if.we), 64'd1);
      chk("wr_nodone", 64'(mem_done), 64'd0);
      if (k == 3) m_merr = 1'b1;
      cycle("wr_req");
    end
    m_busy = 1'b0;
    chk("to_req", 64'(mem_if.req), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_nodone", 64'(mem_done), 64'd0);
    chk("to_err", 64'(mem_err), 64'd1);
    chk("to_mdr_kept", 64'(mem_if.wdata), 64'h55AA);
    idle_in(); err_clr = 1'b1;
    cycle("mem_err_clr");
    chk("mem_err_cleared", 64'(mem_err), 64'd0);

    idle_in(); c_value = 32'h7; c_out = 1'b1; reg_in[0] = 1'b1; reg_in[5] = 1'b1;
    cycle("r0_write");
    idle_in(); reg_out[0] = 1'b1; c_out = 1'b1; c_value = 32'h7;
    cycle("r0_read");
    chk("r0_zero", 64'(bus), 64'd0);
    idle_in(); reg_out[5] = 1'b1; err_clr = 1'b1;
    cycle("r5_read");
    chk("r5_val", 64'(bus), 64'h7);

    for (int t = 0; t < 300; t++) begin
      logic [22:0] en;
      int k;
      idle_in();
      en = '0;
      k = $urandom_range(0, 23);
      if (k < 23) en[k] = 1'b1;
      if ($urandom_range(0, 4) == 0) en[$urandom_range(0, 22)] = 1'b1;
      reg_out = en[15:0];
      {c_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out} = en[22:16];
      reg_in = 16'($urandom) & 16'($urandom) & 16'($urandom);
      {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc} = 9'($urandom) & 9'($urandom);
      c_value = $urandom;
      alu_result = {$urandom, $urandom};
      err_clr = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    idle_in(); mem_rd = 1'b1;
    cycle("rd2_start");
    idle_in();
    #1;
    chk("rst_mid_pre", 64'(mem_if.req), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mem_if.req), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_pc", 64'(pc_val), 64'h100);
    @(posedge clk);
    #1;
    reset = 1'b1;
    reset_model();
    idle_in(); reg_out[3] = 1'b1;
    cycle("post_rst");
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_bus_datapath.md
Name: param_bus_datapath

Overview:
- Parametrised successor to the single-bus CPU datapath: general register file, PC, IR, MAR, MDR, Y, Z (double width), HI, LO on one shared bus.
- Adds an MDR/MAR memory handshake FSM with timeout, a PC increment step, an optional hardwired-zero R0, and sticky bus-contention detection.
- The ALU stays external: this block drives its operands and captures its double-width result into Z.

Parameters:
- DATA_W, 32, width of bus and all registers (Z is 2*DATA_W)
- NUM_REGS, 16, general registers R0..R(NUM_REGS-1), 2..32
- R0_ZERO, 0, 1 = R0 reads as 0 and ignores writes
- RESET_PC, 0, PC value after reset
- PC_STEP, 1, PC increment on inc_pc
- MEM_TIMEOUT, 255, cycles in REQ before abort (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- reg_out  in  NUM_REGS  one-hot register bus-drive enables
- reg_in  in  NUM_REGS  register load enables from bus
- pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, c_out  in  1 each  bus-drive enables
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in  in  1 each  load enables
- inc_pc  in  1  PC <= PC + PC_STEP
- c_value  in  DATA_W  immediate/constant source
- alu_result  in  2*DATA_W  external ALU output, captured on z_in
- alu_a, alu_b  out  DATA_W  Y value and bus value to the ALU
- mem_rd, mem_wr  in  1  start a memory read/write
- mem_req, mem_we  out  1  request; write qualifier
- mem_addr, mem_wdata  out  DATA_W  MAR value, MDR value
- mem_ack  in  1  memory completion
- mem_rdata  in  DATA_W  read data
- busy, mem_done, mem_err  out  1  FSM not idle; one-cycle completion pulse; sticky timeout flag
- err_clr  in  1  clears bus_err and mem_err
- bus, pc_val, ir_val  out  DATA_W  observation outputs
- bus_err  out  1  sticky flag: more than one driver enabled

Behaviour:
- Reset (async, reset=0): all registers, Z, HI, LO, Y, IR, MAR, MDR = 0; PC = RESET_PC; FSM = IDLE; all outputs 0 except pc_val = RESET_PC.
- Bus is combinational.
  - Priority: lowest asserted reg_out index, then HI, LO, ZHI, ZLO, PC, MDR, C.
  - With no driver enabled, bus = 0.
  - More than one enable asserted in a cycle sets bus_err on the next edge. bus_err holds until err_clr or reset; err_clr loses to a new set in the same cycle.
- Loads take effect on the rising edge from the current bus value.
  - Several in-enables may load in the same cycle.
  - With R0_ZERO=1, the R0 write is dropped and R0 always reads 0.
- PC: pc_in has priority over inc_pc. Addition wraps modulo 2^DATA_W.
- Z loads alu_result on z_in. alu_a = Y and alu_b = bus, both combinational.
- Memory FSM states: IDLE, REQ, DONE.
  - IDLE: mem_rd or mem_wr moves the FSM to REQ next cycle. If both are asserted, the read wins. A write latches mem_we=1.
  - REQ: mem_req=1. mem_addr = MAR and mem_wdata = MDR, both held stable.
    - On mem_ack: for a read, MDR <= mem_rdata. Go to DONE.
    - The timeout counter resets on entry and increments each REQ cycle. When it reaches MEM_TIMEOUT without ack: set mem_err, go to IDLE, no MDR update, no mem_done.
  - DONE: mem_done=1 for exactly one cycle, then IDLE. A new command is accepted only in IDLE, never in DONE.
  - busy = (state != IDLE). mem_rd/mem_wr while busy are ignored, not queued.
  - While busy, mar_in and mdr_in are ignored so address and data stay stable. The memory load of MDR always beats bus loads.
- Reset mid-transaction: FSM returns to IDLE at once and mem_req drops asynchronously.
- A late mem_ack in IDLE or DONE is ignored.

Decomposition:
- Shared package:
  - bus-source index constants (REG0 base, HI, LO, ZHI, ZLO, PC, MDR, C)
  - FSM state enum (IDLE, REQ, DONE)
  - a function computing the source-count width
- Sub-module mem_handshake_fsm: FSM, timeout counter, mem_done/mem_err, and the busy gating of MAR/MDR.
- The top level holds the register file, bus priority mux, and contention detector.

Test Plan:
- Reset with PC_STEP=4, RESET_PC=0x100; then inc_pc for 3 cycles -> pc_val=0x10C. Assert pc_in with bus=0x20 and inc_pc together -> pc_val=0x20.
- c_value=0x5 with c_out and reg_in[3] -> R3=5. Then reg_out[3] and y_in -> Y=5. Set alu_result=0x0000000A_0000000F with z_in, then zlo_out with reg_in[4] -> R4=0xF; zhi_out with hi_in -> HI=0xA.
- reg_out[2] and pc_out together -> bus=R2 value, bus_err=1 next cycle. err_clr -> bus_err=0.
- MAR=0x40, mem_rd; memory acks after 3 cycles with 0xDEADBEEF -> mem_req high 3 cycles, MDR=0xDEADBEEF, one-cycle mem_done. mdr_in asserted during REQ is ignored.
- MEM_TIMEOUT=4, mem_wr with no ack -> mem_req high 4 cycles, then mem_err=1, busy=0, no mem_done.
- R0_ZERO=1: reg_in[0] with bus=0x7 -> reg_out[0] drives 0. Pull reset low during REQ -> mem_req=0 immediately and FSM in IDLE.
